// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the line-granular data-memory responder.
package dmem_pkg;
   localparam int unsigned LINE_W  = 256;
   localparam int unsigned DEPTH   = 512;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned IDX_LSB = 5;
   localparam int unsigned IDX_W   = 9;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } dmem_state_t;
endpackage

// File: rtl/dmem_line_array.sv
// Single-port DEPTH x LINE_W line storage: synchronous write, registered read.
module dmem_line_array
   import dmem_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);

   logic [LINE_W-1:0] memory [DEPTH];
   logic [LINE_W-1:0] rdata_q;

   // Storage has no reset; contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         memory[idx_i] <= wdata_i;
      end
   end

   // Read register holds its value across writes and idle cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= memory[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Memory end of the D-cache refill/write-back port: one line access per request,
// completed LATENCY cycles after accept with a single-cycle ack.
module dmem_line_responder
   import dmem_pkg::*;
#(
   parameter int unsigned LATENCY = 10
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);

   dmem_state_t       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              we_q;
   logic [LINE_W-1:0] wdata_q;
   logic              ack_q;
   logic              access_c;
   logic              unused_addr_c;

   assign unused_addr_c = ^{addr_i[ADDR_W-1:IDX_LSB+IDX_W], addr_i[IDX_LSB-1:0]};

   // The array is touched only on the BUSY->ACK edge, so an aborted request never writes.
   assign access_c = (state_q == BUSY) && (cnt_q == CNT_W'(LATENCY - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               if (enable_i) begin
                  idx_q   <= addr_i[IDX_LSB +: IDX_W];
                  we_q    <= write_i;
                  wdata_q <= data_i;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (access_c) begin
                  ack_q   <= 1'b1;
                  state_q <= ACK;
               end
            end
            ACK: begin
               ack_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ack_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   dmem_line_array u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (access_c),
      .we_i    (we_q),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (data_o)
   );

   assign ack_o = ack_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed + randomized bench for dmem_line_responder against a line-array
// reference model with fixed-latency completion.
module tb_dmem_line_responder;
   import dmem_pkg::*;

   localparam int unsigned LAT     = 10;
   localparam int unsigned TIMEOUT = 300;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [ADDR_W-1:0] addr_i = '0;
   logic [LINE_W-1:0] data_i = '0;
   logic              enable_i = 1'b0;
   logic              write_i = 1'b0;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;

   logic [ADDR_W-1:0] addr1 = '0;
   logic [LINE_W-1:0] din1 = '0;
   logic              en1 = 1'b0;
   logic              we1 = 1'b0;
   logic              ack1;
   logic [LINE_W-1:0] dout1;

   logic [LINE_W-1:0] mem_model [DEPTH];
   logic [LINE_W-1:0] last_rd;
   int                n_cmp = 0;
   int                n_err = 0;

   always #5 clk_i = ~clk_i;

   dmem_line_responder #(.LATENCY(LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
      .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
   );

   dmem_line_responder #(.LATENCY(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr1), .data_i(din1),
      .enable_i(en1), .write_i(we1), .ack_o(ack1), .data_o(dout1)
   );

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request from IDLE; optionally scrambles the request fields mid-flight.
   task automatic req(input string tag, input logic [ADDR_W-1:0] a, input logic w,
                      input logic [LINE_W-1:0] d, input logic [ADDR_W-1:0] alt_a);
      logic [IDX_W-1:0]  idx;
      logic [LINE_W-1:0] exp_rd;
      int                n;
      idx      = a[IDX_LSB +: IDX_W];
      addr_i   = a;
      write_i  = w;
      data_i   = d;
      enable_i = 1'b1;
      @(posedge clk_i); #1;
      exp_rd = w ? last_rd : mem_model[idx];
      if (w) mem_model[idx] = d;
      n = 0;
      while (!ack_o && n < int'(TIMEOUT)) begin
         if (n == 2) begin
            addr_i  = alt_a;
            data_i  = rand_line();
            write_i = ~w;
         end
         @(posedge clk_i); #1;
         n++;
      end
      enable_i = 1'b0;
      check({tag, "_lat"}, LINE_W'(n), LINE_W'(LAT));
      check({tag, "_data"}, data_o, exp_rd);
      last_rd = exp_rd;
      @(posedge clk_i); #1;
      check({tag, "_ack_drop"}, LINE_W'(ack_o), LINE_W'(0));
   endtask

   initial begin
      logic [LINE_W-1:0] l;
      logic [LINE_W-1:0] deadbeef;
      logic [ADDR_W-1:0] a;
      int                ack_t [$];
      int                n;

      for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = rand_line();
      for (int k = 0; k < 16; k++) l[LINE_W-1-16*k -: 16] = 16'(k * 16'h1111);
      mem_model[0] = l;
      for (int k = 0; k < 16; k++) l[LINE_W-1-16*k -: 16] = 16'(((k + 8) % 16) * 16'h1111);
      mem_model[1] = l;
      mem_model[2] = {16{16'hECFA}};
      mem_model[16] = {4{64'h0123_4567_89AB_CDEF}};
      for (int k = 0; k < 16; k++) l[LINE_W-1-16*k -: 16] = 16'((k + 1) * 16'h1001);
      mem_model[32] = l;
      for (int i = 0; i < int'(DEPTH); i++) begin
         dut.u_array.memory[i]  <= mem_model[i];
         dut1.u_array.memory[i] <= mem_model[i];
      end
      last_rd = '0;
      #2;
      check("rst_ack", LINE_W'(ack_o), LINE_W'(0));
      check("rst_data", data_o, '0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      req("rd_line0", 32'h0000_0000, 1'b0, '0, 32'h0000_0000);
      deadbeef = {8{32'hDEADBEEF}};
      req("wr_220", 32'h0000_0220, 1'b1, deadbeef, 32'h0000_0220);
      req("rd_220", 32'h0000_0220, 1'b0, '0, 32'h0000_0220);
      check("rd_220_val", data_o, deadbeef);
      req("rd_200", 32'h0000_0200, 1'b0, '0, 32'h0000_0200);

      // Held enable: acks every LAT+2 cycles.
      addr_i = 32'h0000_0040; write_i = 1'b0; enable_i = 1'b1;
      @(posedge clk_i); #1;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk_i); #1;
         if (ack_o) begin
            ack_t.push_back(c);
            check("held_data", data_o, mem_model[2]);
            if (ack_t.size() == 3) enable_i = 1'b0;
         end
      end
      check("held_cnt", LINE_W'(ack_t.size()), LINE_W'(3));
      if (ack_t.size() == 3) begin
         check("held_t0", LINE_W'(ack_t[0]), LINE_W'(LAT));
         check("held_t1", LINE_W'(ack_t[1]), LINE_W'(2 * LAT + 2));
         check("held_t2", LINE_W'(ack_t[2]), LINE_W'(3 * LAT + 4));
      end
      last_rd = mem_model[2];

      req("alias_4000", 32'h0000_4000, 1'b0, '0, 32'h0000_0020);

      // Reset in the middle of a write aborts it.
      addr_i = 32'h0000_0400; write_i = 1'b1; data_i = rand_line(); enable_i = 1'b1;
      @(posedge clk_i); #1;
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b1; enable_i = 1'b0;
      #1;
      check("abort_ack", LINE_W'(ack_o), LINE_W'(0));
      check("abort_data", data_o, '0);
      last_rd = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      req("rd_after_abort", 32'h0000_0400, 1'b0, '0, 32'h0000_0400);

      // Single-cycle latency build with enable held.
      ack_t.delete();
      addr1 = 32'h0000_0020; we1 = 1'b0; en1 = 1'b1;
      @(posedge clk_i); #1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk_i); #1;
         if (ack1) begin
            ack_t.push_back(c);
            check("lat1_data", dout1, mem_model[1]);
            if (ack_t.size() == 2) en1 = 1'b0;
         end
      end
      check("lat1_cnt", LINE_W'(ack_t.size()), LINE_W'(2));
      if (ack_t.size() == 2) begin
         check("lat1_t0", LINE_W'(ack_t[0]), LINE_W'(1));
         check("lat1_t1", LINE_W'(ack_t[1]), LINE_W'(4));
      end

      // Random mix of reads and writes over a small line window.
      for (int t = 0; t < 24; t++) begin
         a = $urandom;
         a[IDX_LSB +: IDX_W] = IDX_W'($urandom_range(64, 71));
         n = $urandom_range(0, 1);
         req("rand", a, n[0], rand_line(), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
